// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// Signalling: no valid/ready pair here. The datapath presents buf1/buf2 contents every cycle and
// the controller answers combinationally in that same cycle (enables, flush, bubble, mul/div pulses).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_id_instr;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic             branch_taken;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             md_start;
  logic             md_abort;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_instr, id_ex_mem_read, id_ex_rt, branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, md_start, md_abort,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  if_id_instr, id_ex_mem_read, id_ex_rt, branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, md_start, md_abort,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// MIPS pipeline control: load-use stall, taken-branch flush and fixed-latency mul/div sequencing,
// with saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd2
  } state_e;

  // md_cnt holds the stall cycles still owed after the md_start cycle; release happens at zero.
  localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

  state_e           state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_used;
  logic       rt_used;
  logic       is_md;
  logic       lu;

  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic md_start;
  logic md_abort;

  assign op      = hz.if_id_instr[31:26];
  assign rs      = hz.if_id_instr[25:21];
  assign rt      = hz.if_id_instr[20:16];
  assign funct   = hz.if_id_instr[5:0];
  assign rs_used = |hz.if_id_instr;
  assign rt_used = ((op == 6'h00) && (|hz.if_id_instr)) ||
                   (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign is_md   = (op == 6'h00) && (funct[5:2] == 4'b0110);
  assign lu      = hz.id_ex_mem_read && (|hz.id_ex_rt) &&
                   ((rs_used && (rs == hz.id_ex_rt)) || (rt_used && (rt == hz.id_ex_rt)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    md_start     = 1'b0;
    md_abort     = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    if (reset) begin
      state_d  = RUN;
      md_cnt_d = 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (is_md) begin
            md_start     = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            md_cnt_d     = MD_RELOAD;
            state_d      = MD_WAIT;
          end
        end
        MD_WAIT: begin
          // A taken branch is older than the held mul/div op, so the op is discarded.
          if (hz.branch_taken) begin
            md_abort     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
          end else if (md_cnt_q == 8'd0) begin
            state_d = RUN;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            md_cnt_d     = md_cnt_q - 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_en && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + 1'b1;
    if (if_id_flush && (flush_count_q != {CNT_W{1'b1}})) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      md_cnt_q      <= 8'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.md_start     = md_start;
  assign hz.md_abort     = md_abort;
  assign hz.state        = state_q;
  assign hz.stall_count  = stall_count_q;
  assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cases from the hazard rules plus a randomized run
// checked every cycle against a penalty-counting reference model (16-bit and 4-bit counter builds).
module tb_pipeline_hazard_ctrl;

  localparam int MD_LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_rd = 1'b0;
  logic [4:0]  ld_rt = 5'd0;
  logic        br = 1'b0;
  logic        chk_en = 1'b0;

  int compared = 0;
  int mismatched = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if_m ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if_s ();

  assign if_m.if_id_instr = instr;
  assign if_m.id_ex_mem_read = mem_rd;
  assign if_m.id_ex_rt = ld_rt;
  assign if_m.branch_taken = br;
  assign if_s.if_id_instr = instr;
  assign if_s.id_ex_mem_read = mem_rd;
  assign if_s.id_ex_rt = ld_rt;
  assign if_s.branch_taken = br;

  pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(16)) dut   (.clk(clk), .reset(rst), .hz(if_m));
  pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(4))  dut_s (.clk(clk), .reset(rst), .hz(if_s));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic m, input logic [4:0] r, input logic b);
    instr = i; mem_rd = m; ld_rt = r; br = b;
  endtask

  // ---------------- reference model ----------------
  // md_busy: a mul/div op is being waited on; md_left: stall cycles still owed for it.
  logic       md_busy = 1'b0;
  int         md_left = 0;
  int         m_stall16 = 0, m_flush16 = 0, m_stall4 = 0, m_flush4 = 0;
  logic [7:0] exp_q[$];

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  always @(negedge clk) begin
    int op, rs, rt, fn;
    logic rs_u, rt_u, md, hz_lu;
    logic e_pc, e_en, e_fl, e_bub, e_st, e_ab;
    logic [7:0] e_vec, a_vec;
    op = int'(instr >> 26); rs = int'((instr >> 21) & 32'h1f);
    rt = int'((instr >> 16) & 32'h1f); fn = int'(instr & 32'h3f);
    rs_u = (instr != 0);
    rt_u = (op == 0 && instr != 0) || op == 4 || op == 5 || op == 43;
    md = (op == 0) && (fn >= 24) && (fn <= 27);
    hz_lu = mem_rd && (ld_rt != 0) && ((rs_u && rs == int'(ld_rt)) || (rt_u && rt == int'(ld_rt)));
    e_pc = 1; e_en = 1; e_fl = 0; e_bub = 0; e_st = 0; e_ab = 0;

    if (!rst) begin
      if (!md_busy) begin
        if (br) begin e_fl = 1; e_bub = 1; end
        else if (hz_lu) begin e_pc = 0; e_en = 0; e_bub = 1; end
        else if (md) begin e_st = 1; e_pc = 0; e_en = 0; e_bub = 1; end
      end else begin
        if (br) begin e_ab = 1; e_fl = 1; e_bub = 1; end
        else if (md_left > 0) begin e_pc = 0; e_en = 0; e_bub = 1; end
      end
    end

    if (chk_en) begin
      exp_q.push_back({e_pc, e_en, e_fl, e_bub, e_st, e_ab, (md_busy ? 2'd2 : 2'd0)});
      a_vec = {if_m.pc_en, if_m.if_id_en, if_m.if_id_flush, if_m.id_ex_bubble,
               if_m.md_start, if_m.md_abort, if_m.state};
      e_vec = exp_q.pop_front();
      check("ctrl{pc,en,fl,bub,st,ab,state}", {24'h0, a_vec}, {24'h0, e_vec});
      check("counts16{stall,flush}", {if_m.stall_count, if_m.flush_count},
            {m_stall16[15:0], m_flush16[15:0]});
      check("counts4{stall,flush}", {24'h0, if_s.stall_count, if_s.flush_count},
            {24'h0, m_stall4[3:0], m_flush4[3:0]});
    end

    // Advance model to the state after the coming rising edge.
    if (rst) begin
      md_busy = 0; md_left = 0;
      m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      if (!e_pc) begin m_stall16 = sat_inc(m_stall16, 65535); m_stall4 = sat_inc(m_stall4, 15); end
      if (e_fl)  begin m_flush16 = sat_inc(m_flush16, 65535); m_flush4 = sat_inc(m_flush4, 15); end
      if (!md_busy) begin
        if (e_st) begin md_busy = 1; md_left = MD_LAT - 1; end
      end else if (e_ab || md_left == 0) begin
        md_busy = 0;
      end else begin
        md_left = md_left - 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: return {6'h00, a, b, 5'd10, 5'd0, 6'h20};
      1: return {6'h00, a, b, 10'd0, 4'b0110, 2'($urandom_range(0, 3))};
      2: return {6'h04, a, b, 16'h0010};
      3: return {6'h2B, a, b, 16'h0000};
      4: return {6'h23, a, b, 16'h0004};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    int stalls;
    drive(32'h00850018, 1'b1, 5'd8, 1'b1);
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset pc_en forced", {31'h0, if_m.pc_en}, 32'd1);
    check("reset md_start forced", {31'h0, if_m.md_start}, 32'd0);
    check("reset flush forced", {31'h0, if_m.if_id_flush}, 32'd0);
    tick(); rst = 1'b0; drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("post-reset state", {30'h0, if_m.state}, 32'd0);
    check("post-reset stall_count", {16'h0, if_m.stall_count}, 32'd0);

    // Load-use against rs of add $10,$8,$11
    tick(); drive(32'h010B5020, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    check("lu pc_en", {31'h0, if_m.pc_en}, 32'd0);
    check("lu if_id_en", {31'h0, if_m.if_id_en}, 32'd0);
    check("lu bubble", {31'h0, if_m.id_ex_bubble}, 32'd1);
    tick(); drive(32'h010B5020, 1'b0, 5'd8, 1'b0);
    @(negedge clk);
    check("lu release pc_en", {31'h0, if_m.pc_en}, 32'd1);
    check("lu stall_count", {16'h0, if_m.stall_count}, 32'd1);

    // rt use by sw, register $0, and a non-matching load
    tick(); drive(32'hAD280000, 1'b1, 5'd8, 1'b0);
    @(negedge clk); check("sw rt stall", {31'h0, if_m.pc_en}, 32'd0);
    tick(); drive(32'hAD280000, 1'b1, 5'd0, 1'b0);
    @(negedge clk); check("sw $0 no stall", {31'h0, if_m.pc_en}, 32'd1);
    tick(); drive(32'h010B5020, 1'b1, 5'd9, 1'b0);
    @(negedge clk); check("lw $9 no stall", {31'h0, if_m.pc_en}, 32'd1);
    check("stall_count after rt tests", {16'h0, if_m.stall_count}, 32'd2);

    // mult $4,$5: MD_LAT stall cycles, release on the next
    stalls = 0;
    for (int c = 0; c <= MD_LAT; c++) begin
      tick(); drive(32'h00850018, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      if (!if_m.pc_en) stalls++;
      if (c == 0) check("mult md_start", {31'h0, if_m.md_start}, 32'd1);
      if (c == 1) check("mult md_start single", {31'h0, if_m.md_start}, 32'd0);
    end
    check("mult stall cycles", stalls, MD_LAT);
    check("mult release pc_en", {31'h0, if_m.pc_en}, 32'd1);
    check("mult release bubble", {31'h0, if_m.id_ex_bubble}, 32'd0);
    tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("mult stall_count", {16'h0, if_m.stall_count}, 32'd10);
    check("mult back in RUN", {30'h0, if_m.state}, 32'd0);

    // Abort on the 4th MD_WAIT cycle
    for (int c = 0; c <= 4; c++) begin
      tick(); drive(32'h00850018, 1'b0, 5'd0, (c == 4));
    end
    @(negedge clk);
    check("abort md_abort", {31'h0, if_m.md_abort}, 32'd1);
    check("abort flush", {31'h0, if_m.if_id_flush}, 32'd1);
    check("abort bubble", {31'h0, if_m.id_ex_bubble}, 32'd1);
    tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("abort state", {30'h0, if_m.state}, 32'd0);
    check("abort flush_count", {16'h0, if_m.flush_count}, 32'd1);
    check("abort stall_count", {16'h0, if_m.stall_count}, 32'd14);

    // Branch together with load-use: flush wins
    tick(); drive(32'h010B5020, 1'b1, 5'd8, 1'b1);
    @(negedge clk);
    check("br+lu flush", {31'h0, if_m.if_id_flush}, 32'd1);
    check("br+lu pc_en", {31'h0, if_m.pc_en}, 32'd1);
    tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("br+lu stall_count", {16'h0, if_m.stall_count}, 32'd14);
    check("br+lu flush_count", {16'h0, if_m.flush_count}, 32'd2);

    // Reset asserted mid-MD_WAIT
    for (int c = 0; c < 3; c++) begin
      tick(); drive(32'h00850018, 1'b0, 5'd0, 1'b0);
    end
    tick(); rst = 1'b1; drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("reset in MD_WAIT no abort", {31'h0, if_m.md_abort}, 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("reset in MD_WAIT state", {30'h0, if_m.state}, 32'd0);
    check("reset in MD_WAIT pc_en", {31'h0, if_m.pc_en}, 32'd1);
    check("reset in MD_WAIT counters", {if_m.stall_count, if_m.flush_count}, 32'd0);

    // Saturation of the 4-bit counter
    for (int c = 0; c < 20; c++) begin
      tick(); drive(32'h010B5020, 1'b1, 5'd8, 1'b0);
    end
    tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("sat stall_count 4b", {28'h0, if_s.stall_count}, 32'd15);
    check("sat stall_count 16b", {16'h0, if_m.stall_count}, 32'd20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      drive(rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
    end
    tick(); rst = 1'b0; drive(32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
